// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the VGA output stage and renderer.
//   hcount      : current pixel column
//   vcount      : current line
//   hsync/vsync : sync pulses, polarity set by the generator's SYNC_ACTIVE
//   blank       : 1 outside the visible region
//   line_start  : one-cycle pulse at hcount==0
//   frame_start : one-cycle pulse at hcount==0 and vcount==0
// master = timing generator, slave = consumer.
interface vga_timing_gen_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, blank, line_start, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, blank, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480 @ 72 Hz, 31.5 MHz pixel clock).
// Ports:
//   pixel_clock : the only clock
//   reset       : synchronous, active-high
//   vga         : vga_timing_gen_if.master carrying counters, syncs, blank and
//                 the line/frame start pulses
// All outputs are registered and decoded from the next-state counter values,
// so every output describes the counter values shown in the same cycle.
// Optional feature macro: VGA_TIMING_SYNC_DELAY_EN -- when defined, hsync,
// vsync and blank pass through SYNC_DELAY extra register stages so they line
// up with a renderer whose pixel output lags hcount/vcount by that amount.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 40,
  parameter int unsigned H_BP        = 128,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 9,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 28,
  parameter int unsigned SYNC_ACTIVE = 0,
  parameter int unsigned SYNC_DELAY  = 2
) (
  input  logic              pixel_clock,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HW       = 11;
  localparam int unsigned VW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = 1'(SYNC_ACTIVE);
  localparam logic        SYNC_OFF = ~SYNC_ON;

  // Elaboration-time guard: counters are 11/10 bits wide.
  if (H_TOTAL > 2048 || V_TOTAL > 1024 || SYNC_DELAY > 1024) begin : g_bad_params
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [HW-1:0] hcount_q, hcount_nxt;
  logic [VW-1:0] vcount_q, vcount_nxt;
  logic          hsync_q, hsync_nxt;
  logic          vsync_q, vsync_nxt;
  logic          blank_q, blank_nxt;
  logic          line_start_q, line_start_nxt;
  logic          frame_start_q, frame_start_nxt;

  // Next counter position and its decode.
  always_comb begin
    hcount_nxt = hcount_q + HW'(1);
    vcount_nxt = vcount_q;
    if (hcount_q == HW'(H_TOTAL - 1)) begin
      hcount_nxt = '0;
      vcount_nxt = (vcount_q == VW'(V_TOTAL - 1)) ? '0 : vcount_q + VW'(1);
    end

    hsync_nxt = ((hcount_nxt >= HW'(HS_START)) && (hcount_nxt < HW'(HS_END)))
                ? SYNC_ON : SYNC_OFF;
    vsync_nxt = ((vcount_nxt >= VW'(VS_START)) && (vcount_nxt < VW'(VS_END)))
                ? SYNC_ON : SYNC_OFF;
    blank_nxt       = (hcount_nxt >= HW'(H_ACTIVE)) || (vcount_nxt >= VW'(V_ACTIVE));
    line_start_nxt  = (hcount_nxt == '0);
    frame_start_nxt = (hcount_nxt == '0) && (vcount_nxt == '0);
  end

  // Counter and decode registers; reset state is the decode of (0,0).
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_nxt;
      vcount_q      <= vcount_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      blank_q       <= blank_nxt;
      line_start_q  <= line_start_nxt;
      frame_start_q <= frame_start_nxt;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  // Delay line for sync/blank; bit 0 is the first stage, MSB drives the output.
  logic [SYNC_DELAY-1:0] hsync_dly;
  logic [SYNC_DELAY-1:0] vsync_dly;
  logic [SYNC_DELAY-1:0] blank_dly;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      hsync_dly <= {SYNC_DELAY{SYNC_OFF}};
      vsync_dly <= {SYNC_DELAY{SYNC_OFF}};
      blank_dly <= {SYNC_DELAY{1'b1}};
    end else begin
      hsync_dly <= (hsync_dly << 1) | SYNC_DELAY'(hsync_q);
      vsync_dly <= (vsync_dly << 1) | SYNC_DELAY'(vsync_q);
      blank_dly <= (blank_dly << 1) | SYNC_DELAY'(blank_q);
    end
  end

  assign vga.hsync = hsync_dly[SYNC_DELAY-1];
  assign vga.vsync = vsync_dly[SYNC_DELAY-1];
  assign vga.blank = blank_dly[SYNC_DELAY-1];
`else
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.blank = blank_q;
`endif

endmodule
